ioctl_rom_router: RTL and testbench
===================================

IOCTL_ROM_ROUTER -- requirements
Module: ioctl_rom_router

Interface
REQ-001 Parameter ROM_SIZE, default 25'h2C500: exact ROM byte count required for a valid index-0 download.
REQ-002 clk_sys  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ioctl_download  in  1  HPS transfer active.
REQ-005 ioctl_wr  in  1  one-cycle byte-valid strobe.
REQ-006 ioctl_addr  in  25  byte address within transfer.
REQ-007 ioctl_dout  in  8  byte data.
REQ-008 ioctl_index  in  8  transfer type: 0 = ROM, 1 = config header, 254 = DIP.
REQ-009 rom_addr  out  17  byte offset within the selected region.
REQ-010 rom_data  out  8  registered copy of ioctl_dout.
REQ-011 rom_we  out  4  one-hot region write strobe: [0] main 0x00000-0x07FFF, [1] sound 0x08000-0x0BFFF, [2] gfx 0x0C000-0x2BFFF, [3] PROM 0x2C000-0x2C4FF.
REQ-012 is_bootleg  out  2  header byte 0 bits [1:0].
REQ-013 is_japan  out  1  header byte 0 bit 4.
REQ-014 dip_sw0, dip_sw1, dip_sw2  out  8 each  DIP bytes 0..2, active-low as received.
REQ-015 rom_ready  out  1  level; set after a complete, correctly sized ROM load.
REQ-016 rom_error  out  1  level; set on a ROM load with wrong size or out-of-map bytes.
REQ-017 checksum  out  16  modulo-2^16 sum of all accepted ROM bytes.
REQ-018 load_done  out  1  one-cycle pulse at the end of any index-0 download.

Function
REQ-019 The FSM SHALL have states IDLE, ROM, CFG, DIP, CHECK.
REQ-020 In IDLE, the FSM SHALL move on the rising edge of ioctl_download: to ROM if index 0, CFG if index 1, DIP if index 254, and otherwise stay in IDLE, ignoring the transfer until download falls.
REQ-021 On entering ROM, the block SHALL clear byte_count (25 b), checksum, rom_ready and rom_error.
REQ-022 In ROM, each ioctl_wr SHALL produce rom_we, rom_addr and rom_data exactly one cycle later, lasting one cycle; rom_addr is ioctl_addr minus the region base, truncated to 17 b.
REQ-023 A ROM byte at an address of 0x2C500 or above SHALL assert no rom_we, SHALL set rom_error, and SHALL still increment byte_count.
REQ-024 Each in-map ROM byte SHALL add to checksum, with wrap-around, and SHALL increment byte_count.
REQ-025 On the falling edge of ioctl_download in ROM, the FSM SHALL go to CHECK.
REQ-026 CHECK SHALL last exactly one cycle, pulse load_done, set rom_ready if byte_count == ROM_SIZE and rom_error is clear, otherwise set rom_error, then return to IDLE.
REQ-027 In CFG, ioctl_wr at address 0 SHALL latch is_bootleg and is_japan; all other addresses SHALL be ignored; download falling SHALL return the FSM to IDLE.
REQ-028 In DIP, ioctl_wr at addresses 0..2 SHALL latch the matching dip_sw register; addresses 3..7 SHALL be accepted and discarded; addresses of 8 or above SHALL be ignored; download falling SHALL return the FSM to IDLE.
REQ-029 ioctl_wr while ioctl_download is low SHALL be ignored in every state.
REQ-030 rom_we SHALL never have more than one bit set.
REQ-031 CFG and DIP loads SHALL NOT alter rom_ready, rom_error or checksum.
REQ-032 If ioctl_wr coincides with the falling edge of download, the byte SHALL be processed before the state transition.

Reset
REQ-033 On reset, the FSM SHALL go to IDLE and rom_we, rom_addr, rom_data, checksum, rom_ready, rom_error, load_done and is_japan SHALL be 0.
REQ-034 On reset, is_bootleg SHALL be 2'b00 and dip_sw0..2 SHALL be 8'hFF.
REQ-035 Reset during ROM SHALL abort the load with no load_done and rom_ready = 0; the next index-0 download SHALL restart from a clean state.

Verification
REQ-036 Full ROM of 0x2C500 bytes, each byte = addr[7:0] -> every rom_we bit seen, last gfx write at rom_addr 0x1FFFF, load_done pulses once, rom_ready = 1, checksum equals the model sum.
REQ-037 ROM truncated to 0x2C4FF bytes -> rom_error = 1, rom_ready = 0, load_done pulses.
REQ-038 ROM with an extra byte at 0x2C500 -> no rom_we for that byte, rom_error = 1.
REQ-039 Index 1 with byte 0 = 8'h12 -> is_bootleg = 2'b10, is_japan = 1; rom_ready unchanged.
REQ-040 Index 254 with bytes FE,7F,00,55 -> dip_sw0/1/2 = FE/7F/00; byte 3 has no effect.
REQ-041 Reset asserted mid-ROM at byte 0x1000, then a full reload -> outputs at reset values, then rom_ready = 1 after the reload.

Source files
------------

// File: rtl/ioctl_rom_router.sv
// ioctl_rom_router: routes HPS ioctl downloads to ROM regions, a config
// header and DIP switch registers, and reports ROM load size and checksum.
`timescale 1ns/1ps
module ioctl_rom_router #(
   parameter logic [24:0] ROM_SIZE = 25'h2C500
) (
   input  logic        i_clk_sys,
   input  logic        i_reset,
   input  logic        i_ioctl_download,
   input  logic        i_ioctl_wr,
   input  logic [24:0] i_ioctl_addr,
   input  logic [7:0]  i_ioctl_dout,
   input  logic [7:0]  i_ioctl_index,
   output logic [16:0] o_rom_addr,
   output logic [7:0]  o_rom_data,
   output logic [3:0]  o_rom_we,
   output logic [1:0]  o_is_bootleg,
   output logic        o_is_japan,
   output logic [7:0]  o_dip_sw0,
   output logic [7:0]  o_dip_sw1,
   output logic [7:0]  o_dip_sw2,
   output logic        o_rom_ready,
   output logic        o_rom_error,
   output logic [15:0] o_checksum,
   output logic        o_load_done
);

   // ROM map region ends (exclusive) and 17-bit region bases.
   localparam logic [24:0] MAIN_END  = 25'h08000;
   localparam logic [24:0] SOUND_END = 25'h0C000;
   localparam logic [24:0] GFX_END   = 25'h2C000;
   localparam logic [24:0] PROM_END  = 25'h2C500;
   // Bases truncated to 17 bits; the offset subtraction wraps modulo 2^17,
   // which equals the low 17 bits of the full-width subtraction.
   localparam logic [16:0] SOUND_BASE = 17'h08000;
   localparam logic [16:0] GFX_BASE   = 17'h0C000;
   localparam logic [16:0] PROM_BASE  = 17'h0C000;

   typedef enum logic [2:0] {S_IDLE, S_ROM, S_CFG, S_DIP, S_CHECK} state_t;

   state_t      r_state;
   logic        r_dl_d;
   logic [24:0] r_byte_count;
   logic [16:0] r_rom_addr;
   logic [7:0]  r_rom_data;
   logic [3:0]  r_rom_we;
   logic [1:0]  r_is_bootleg;
   logic        r_is_japan;
   logic [7:0]  r_dip_sw0;
   logic [7:0]  r_dip_sw1;
   logic [7:0]  r_dip_sw2;
   logic        r_rom_ready;
   logic        r_rom_error;
   logic [15:0] r_checksum;
   logic        r_load_done;

   logic        w_dl_rise;
   logic        w_dl_fall;
   logic        w_byte;
   logic        w_in_map;
   logic [3:0]  w_region_we;
   logic [16:0] w_region_off;

   assign w_dl_rise = i_ioctl_download & ~r_dl_d;
   assign w_dl_fall = ~i_ioctl_download & r_dl_d;
   // A byte only counts while the transfer is active.
   assign w_byte    = i_ioctl_download & i_ioctl_wr;
   assign w_in_map  = |w_region_we;

   // Decode the ROM byte address into a one-hot region and region offset.
   always_comb begin
      w_region_we  = 4'b0000;
      w_region_off = i_ioctl_addr[16:0];
      if (i_ioctl_addr < MAIN_END) begin
         w_region_we  = 4'b0001;
      end else if (i_ioctl_addr < SOUND_END) begin
         w_region_we  = 4'b0010;
         w_region_off = i_ioctl_addr[16:0] - SOUND_BASE;
      end else if (i_ioctl_addr < GFX_END) begin
         w_region_we  = 4'b0100;
         w_region_off = i_ioctl_addr[16:0] - GFX_BASE;
      end else if (i_ioctl_addr < PROM_END) begin
         w_region_we  = 4'b1000;
         w_region_off = i_ioctl_addr[16:0] - PROM_BASE;
      end
   end

   // Download FSM with all outputs registered.
   always_ff @(posedge i_clk_sys or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_dl_d       <= 1'b0;
         r_byte_count <= '0;
         r_rom_addr   <= '0;
         r_rom_data   <= '0;
         r_rom_we     <= '0;
         r_is_bootleg <= 2'b00;
         r_is_japan   <= 1'b0;
         r_dip_sw0    <= 8'hFF;
         r_dip_sw1    <= 8'hFF;
         r_dip_sw2    <= 8'hFF;
         r_rom_ready  <= 1'b0;
         r_rom_error  <= 1'b0;
         r_checksum   <= '0;
         r_load_done  <= 1'b0;
      end else begin
         r_dl_d      <= i_ioctl_download;
         r_rom_we    <= 4'b0000;
         r_load_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_dl_rise) begin
                  case (i_ioctl_index)
                     8'd0: begin
                        r_state      <= S_ROM;
                        r_byte_count <= '0;
                        r_checksum   <= '0;
                        r_rom_ready  <= 1'b0;
                        r_rom_error  <= 1'b0;
                     end
                     8'd1:    r_state <= S_CFG;
                     8'd254:  r_state <= S_DIP;
                     default: r_state <= S_IDLE;
                  endcase
               end
            end
            S_ROM: begin
               if (w_byte) begin
                  r_byte_count <= r_byte_count + 25'd1;
                  r_rom_data   <= i_ioctl_dout;
                  if (w_in_map) begin
                     r_rom_we   <= w_region_we;
                     r_rom_addr <= w_region_off;
                     r_checksum <= r_checksum + {8'h00, i_ioctl_dout};
                  end else begin
                     r_rom_error <= 1'b1;
                  end
               end
               // A byte strobed in the last active cycle is already handled
               // above; the fall is only seen on the following cycle.
               if (w_dl_fall) begin
                  r_state <= S_CHECK;
               end
            end
            S_CFG: begin
               if (w_byte && i_ioctl_addr == 25'd0) begin
                  r_is_bootleg <= i_ioctl_dout[1:0];
                  r_is_japan   <= i_ioctl_dout[4];
               end
               if (w_dl_fall) begin
                  r_state <= S_IDLE;
               end
            end
            S_DIP: begin
               // Bytes 3..7 are reserved DIP bytes and are simply dropped.
               if (w_byte && i_ioctl_addr < 25'd8) begin
                  case (i_ioctl_addr[2:0])
                     3'd0:    r_dip_sw0 <= i_ioctl_dout;
                     3'd1:    r_dip_sw1 <= i_ioctl_dout;
                     3'd2:    r_dip_sw2 <= i_ioctl_dout;
                     default: ;
                  endcase
               end
               if (w_dl_fall) begin
                  r_state <= S_IDLE;
               end
            end
            S_CHECK: begin
               r_load_done <= 1'b1;
               if (r_byte_count == ROM_SIZE && !r_rom_error) begin
                  r_rom_ready <= 1'b1;
               end else begin
                  r_rom_error <= 1'b1;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_rom_addr   = r_rom_addr;
   assign o_rom_data   = r_rom_data;
   assign o_rom_we     = r_rom_we;
   assign o_is_bootleg = r_is_bootleg;
   assign o_is_japan   = r_is_japan;
   assign o_dip_sw0    = r_dip_sw0;
   assign o_dip_sw1    = r_dip_sw1;
   assign o_dip_sw2    = r_dip_sw2;
   assign o_rom_ready  = r_rom_ready;
   assign o_rom_error  = r_rom_error;
   assign o_checksum   = r_checksum;
   assign o_load_done  = r_load_done;

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Testbench for ioctl_rom_router: scoreboard of expected ROM writes plus
// per-scenario tasks for load status, config, DIP and reset behaviour.
`timescale 1ns/1ps
module tb_ioctl_rom_router;

   // The DUT is built with a reduced ROM_SIZE so a complete load fits a short
   // run; the image is five 256-byte segments straddling every region edge.
   localparam logic [24:0] TB_ROM_SIZE = 25'h500;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        download = 1'b0;
   logic        wr = 1'b0;
   logic [24:0] addr = '0;
   logic [7:0]  dout = '0;
   logic [7:0]  index = '0;
   logic [16:0] rom_addr;
   logic [7:0]  rom_data;
   logic [3:0]  rom_we;
   logic [1:0]  is_bootleg;
   logic        is_japan;
   logic [7:0]  dip0, dip1, dip2;
   logic        rom_ready, rom_error, load_done;
   logic [15:0] checksum;

   ioctl_rom_router #(.ROM_SIZE(TB_ROM_SIZE)) dut (
      .i_clk_sys(clk), .i_reset(rst), .i_ioctl_download(download),
      .i_ioctl_wr(wr), .i_ioctl_addr(addr), .i_ioctl_dout(dout),
      .i_ioctl_index(index), .o_rom_addr(rom_addr), .o_rom_data(rom_data),
      .o_rom_we(rom_we), .o_is_bootleg(is_bootleg), .o_is_japan(is_japan),
      .o_dip_sw0(dip0), .o_dip_sw1(dip1), .o_dip_sw2(dip2),
      .o_rom_ready(rom_ready), .o_rom_error(rom_error),
      .o_checksum(checksum), .o_load_done(load_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  we;
      logic [16:0] addr;
      logic [7:0]  data;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ld_count = 0;
   logic [3:0]  we_seen = '0;
   bit          gfx_last_seen = 1'b0;
   logic [15:0] sum_model = '0;

   logic [24:0] reg_base  [4] = '{25'h00000, 25'h08000, 25'h0C000, 25'h2C000};
   logic [24:0] reg_limit [4] = '{25'h08000, 25'h0C000, 25'h2C000, 25'h2C500};
   logic [24:0] seg_start [5] = '{25'h00000, 25'h07F80, 25'h0BF80, 25'h2BF80, 25'h2C400};

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard on every write strobe.
   always @(negedge clk) begin
      if (load_done === 1'b1) ld_count++;
      if (rom_we !== 4'b0000) begin
         we_seen = we_seen | rom_we;
         if (rom_we === 4'b0100 && rom_addr === 17'h1FFFF) gfx_last_seen = 1'b1;
         checks++;
         if ($countones(rom_we) != 1) begin
            errors++;
            $display("FAIL we_onehot: got %b required a single bit", rom_we);
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_we: got we=%b addr=%h data=%h required no write", rom_we, rom_addr, rom_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (rom_we !== e.we || rom_addr !== e.addr || rom_data !== e.data || cyc != e.cyc + 1) begin
               errors++;
               $display("FAIL rom_write: got we=%b addr=%h data=%h cyc=%0d required we=%b addr=%h data=%h cyc=%0d",
                        rom_we, rom_addr, rom_data, cyc, e.we, e.addr, e.data, e.cyc + 1);
            end
         end
      end else begin
         while (sb.size() > 0 && sb[0].cyc + 1 <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_we: got no write required we=%b addr=%h data=%h", e.we, e.addr, e.data);
         end
      end
   end

   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      wr = 1'b1; addr = a; dout = d;
   endtask

   task automatic wr_stop();
      @(posedge clk); #1;
      wr = 1'b0;
   endtask

   task automatic rom_byte(input logic [24:0] a, input logic [7:0] d);
      exp_t e;
      wr_byte(a, d);
      for (int r = 0; r < 4; r++) begin
         if (a >= reg_base[r] && a < reg_limit[r]) begin
            e.we   = 4'(1 << r);
            e.addr = 17'(a - reg_base[r]);
            e.data = d;
            e.cyc  = cyc;
            sb.push_back(e);
            sum_model = sum_model + {8'h00, d};
         end
      end
   endtask

   task automatic start_dl(input logic [7:0] idx);
      @(posedge clk); #1;
      index = idx; download = 1'b1;
      if (idx == 8'd0) sum_model = '0;
   endtask

   task automatic send_image(input bit drop_last, input bit rnd);
      for (int s = 0; s < 5; s++) begin
         for (int i = 0; i < 256; i++) begin
            logic [24:0] a;
            logic [7:0]  d;
            if (!(drop_last && s == 4 && i == 255)) begin
               a = seg_start[s] + 25'(i);
               d = rnd ? 8'($urandom) : a[7:0];
               rom_byte(a, d);
            end
         end
      end
   endtask

   // Ends a ROM download and checks the CHECK outcome.
   task automatic finish_rom(input string name, input logic exp_ready, input logic exp_error);
      int ld0;
      ld0 = ld_count;
      @(posedge clk); #1;
      wr = 1'b0; download = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (ld_count - ld0 != 1) begin
         errors++; $display("FAIL %s_load_done: got %0d pulses required 1", name, ld_count - ld0);
      end
      checks++;
      if (rom_ready !== exp_ready) begin
         errors++; $display("FAIL %s_ready: got %b required %b", name, rom_ready, exp_ready);
      end
      checks++;
      if (rom_error !== exp_error) begin
         errors++; $display("FAIL %s_error: got %b required %b", name, rom_error, exp_error);
      end
      checks++;
      if (checksum !== sum_model) begin
         errors++; $display("FAIL %s_checksum: got %h required %h", name, checksum, sum_model);
      end
      $display("%s: ready=%b error=%b checksum=%h", name, rom_ready, rom_error, checksum);
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if (rom_we !== 4'b0 || rom_addr !== 17'h0 || rom_data !== 8'h0 || checksum !== 16'h0 ||
          rom_ready !== 1'b0 || rom_error !== 1'b0 || load_done !== 1'b0 || is_japan !== 1'b0 ||
          is_bootleg !== 2'b00) begin
         errors++;
         $display("FAIL %s_zero_outputs: got we=%b addr=%h data=%h sum=%h rdy=%b err=%b ld=%b jp=%b bl=%b required all zero",
                  name, rom_we, rom_addr, rom_data, checksum, rom_ready, rom_error, load_done, is_japan, is_bootleg);
      end
      checks++;
      if (dip0 !== 8'hFF || dip1 !== 8'hFF || dip2 !== 8'hFF) begin
         errors++;
         $display("FAIL %s_dip_reset: got %h/%h/%h required FF/FF/FF", name, dip0, dip1, dip2);
      end
      $display("%s: reset values sampled", name);
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1 check_reset_values("reset_async");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_values("reset_release");
   endtask

   task automatic test_full_rom();
      we_seen = '0; gfx_last_seen = 1'b0;
      start_dl(8'd0);
      send_image(1'b0, 1'b0);
      finish_rom("full_rom", 1'b1, 1'b0);
      checks++;
      if (we_seen !== 4'b1111) begin
         errors++; $display("FAIL full_rom_regions: got %b required 1111", we_seen);
      end
      checks++;
      if (gfx_last_seen !== 1'b1) begin
         errors++; $display("FAIL full_rom_gfx_last: got %b required 1", gfx_last_seen);
      end
   endtask

   task automatic test_cfg(input logic [7:0] b0, input logic [1:0] exp_bl, input logic exp_jp);
      logic [15:0] sum0;
      logic        rdy0;
      sum0 = checksum; rdy0 = rom_ready;
      start_dl(8'd1);
      wr_byte(25'd0, b0);
      wr_byte(25'd1, 8'hFF);
      end_cfg_dip();
      checks++;
      if (is_bootleg !== exp_bl || is_japan !== exp_jp) begin
         errors++; $display("FAIL cfg_latch: got bl=%b jp=%b required bl=%b jp=%b", is_bootleg, is_japan, exp_bl, exp_jp);
      end
      checks++;
      if (rom_ready !== rdy0 || checksum !== sum0) begin
         errors++; $display("FAIL cfg_rom_status: got rdy=%b sum=%h required rdy=%b sum=%h", rom_ready, checksum, rdy0, sum0);
      end
      $display("cfg byte0=%h: bootleg=%b japan=%b", b0, is_bootleg, is_japan);
   endtask

   task automatic end_cfg_dip();
      @(posedge clk); #1;
      wr = 1'b0; download = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_dip();
      int ld0;
      ld0 = ld_count;
      start_dl(8'd254);
      wr_byte(25'd0, 8'hFE);
      wr_byte(25'd1, 8'h7F);
      wr_byte(25'd2, 8'h00);
      wr_byte(25'd3, 8'h55);
      wr_byte(25'd9, 8'h11);
      end_cfg_dip();
      checks++;
      if (dip0 !== 8'hFE || dip1 !== 8'h7F || dip2 !== 8'h00) begin
         errors++; $display("FAIL dip_latch: got %h/%h/%h required FE/7F/00", dip0, dip1, dip2);
      end
      checks++;
      if (rom_ready !== 1'b1 || rom_error !== 1'b0 || ld_count != ld0) begin
         errors++; $display("FAIL dip_rom_status: got rdy=%b err=%b ld=%0d required rdy=1 err=0 ld=0", rom_ready, rom_error, ld_count - ld0);
      end
      $display("dip: sw0=%h sw1=%h sw2=%h", dip0, dip1, dip2);
   endtask

   task automatic test_unknown_index();
      int ld0;
      ld0 = ld_count;
      start_dl(8'd5);
      wr_byte(25'd0, 8'h03);
      wr_byte(25'd1, 8'h44);
      end_cfg_dip();
      checks++;
      if (ld_count != ld0 || is_bootleg !== 2'b10 || dip0 !== 8'hFE || rom_ready !== 1'b1) begin
         errors++; $display("FAIL unknown_index: got ld=%0d bl=%b dip0=%h rdy=%b required ld=0 bl=10 dip0=FE rdy=1",
                            ld_count - ld0, is_bootleg, dip0, rom_ready);
      end
      $display("unknown index 5: ignored");
   endtask

   task automatic test_wr_without_download();
      wr_byte(25'h10, 8'hAA);
      wr_stop();
      repeat (3) @(negedge clk);
      checks++;
      if (checksum !== sum_model || rom_ready !== 1'b1) begin
         errors++; $display("FAIL wr_no_download: got sum=%h rdy=%b required sum=%h rdy=1", checksum, rom_ready, sum_model);
      end
      $display("wr without download: sum=%h", checksum);
   endtask

   task automatic test_truncated();
      start_dl(8'd0);
      send_image(1'b1, 1'b1);
      finish_rom("truncated", 1'b0, 1'b1);
   endtask

   task automatic test_extra_byte();
      start_dl(8'd0);
      send_image(1'b0, 1'b1);
      rom_byte(25'h2C500, 8'h5A);
      wr_stop();
      repeat (2) @(negedge clk);
      checks++;
      if (rom_error !== 1'b1) begin
         errors++; $display("FAIL extra_byte_error_early: got %b required 1", rom_error);
      end
      finish_rom("extra_byte", 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_rom();
      int ld0;
      start_dl(8'd0);
      for (int i = 0; i < 25'h1000; i += 16) rom_byte(25'(i), 8'(i >> 4));
      wr_stop();
      repeat (2) @(negedge clk);
      ld0 = ld_count;
      #2 rst = 1'b1; download = 1'b0;
      sb.delete();
      #1 check_reset_values("mid_rom_reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (ld_count != ld0 || rom_ready !== 1'b0) begin
         errors++; $display("FAIL mid_rom_abort: got ld=%0d rdy=%b required ld=0 rdy=0", ld_count - ld0, rom_ready);
      end
      start_dl(8'd0);
      send_image(1'b0, 1'b1);
      finish_rom("reload", 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_full_rom();
      test_cfg(8'h12, 2'b10, 1'b1);
      test_cfg(8'h01, 2'b01, 1'b0);
      test_cfg(8'h12, 2'b10, 1'b1);
      test_dip();
      test_unknown_index();
      test_wr_without_download();
      test_truncated();
      test_extra_byte();
      test_reset_mid_rom();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "timeout");
   end

endmodule
